// File: rtl/bus_ram_pkg.sv
// Shared definitions for the bus RAM: FSM encoding, read-latency limits and
// the constant log2 helper used to size the index and clear counter.
package bus_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_ram_if.sv
// Request/status signals between the bus master and the RAM; the shared
// data bus is carried separately as a tristate net.
interface bus_ram_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] Address;
  logic              Write_en;
  logic              Read_en;
  logic              Ready;
  logic              Rd_valid;
  logic              Addr_err;
  logic              Cmd_err;

  modport master (output Address, Write_en, Read_en,
                  input  Ready, Rd_valid, Addr_err, Cmd_err);
  modport slave  (input  Address, Write_en, Read_en,
                  output Ready, Rd_valid, Addr_err, Cmd_err);
endinterface

// File: rtl/bus_ram_rd_pipe.sv
// Read return pipeline: LAT stages of valid/error/data, last stage drives
// the bus. busy covers every accepted read not yet retired.
module bus_ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              out_vld,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);
  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0]             err_pipe;
  logic [LAT-1:0][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      err_pipe[0] <= in_vld & in_err;
      dat_pipe[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign busy     = |vld_pipe;
  assign out_vld  = vld_pipe[LAT-1];
  assign out_err  = err_pipe[LAT-1];
  assign out_data = dat_pipe[LAT-1];
endmodule

// File: rtl/bus_ram.sv
// Single-port data RAM on the shared memory bus: tristate data bus, 1/2-cycle
// read latency, zero-fill sequencer after reset, address/protocol error pulses.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 16,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  bus_ram_if.slave          bus,
  inout  wire  [DATA_W-1:0] Databus
);
  localparam int IW  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int LAT = (READ_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [IW-1:0]   LAST    = IW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nxt;
  logic [IW-1:0]     clr_cnt, idx;
  logic              in_range, idle, rd_acc, wr_acc, rd_busy;
  logic              cmd_err, wr_aerr, pipe_err, rd_valid;
  logic [DATA_W-1:0] rd_word, rd_data;

  // Full-width compare: out-of-range addresses must never alias into the array.
  assign in_range = {1'b0, bus.Address} < DEPTH_V;
  assign idx      = bus.Address[IW-1:0];
  assign idle     = (state == ST_IDLE);
  assign rd_acc   = idle && bus.Read_en && !bus.Write_en;
  assign wr_acc   = idle && bus.Write_en && !bus.Read_en && !rd_busy;
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.Ready = 1'b0;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST) state_nxt = ST_IDLE;
      ST_IDLE:  bus.Ready = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      cmd_err <= 1'b0;
      wr_aerr <= 1'b0;
    end else begin
      clr_cnt <= (state == ST_CLEAR && state_nxt == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      // A write while reads are in flight would fight the RAM on Databus.
      cmd_err <= idle && bus.Write_en && (bus.Read_en || rd_busy);
      wr_aerr <= wr_acc && !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)        mem[clr_cnt] <= '0;
    else if (wr_acc && in_range)  mem[idx]     <= Databus;
  end

  bus_ram_rd_pipe #(.DATA_W(DATA_W), .LAT(LAT)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_err   (!in_range),
    .in_data  (rd_word),
    .busy     (rd_busy),
    .out_vld  (rd_valid),
    .out_err  (pipe_err),
    .out_data (rd_data)
  );

  assign bus.Rd_valid = rd_valid;
  assign bus.Addr_err = wr_aerr | pipe_err;
  assign bus.Cmd_err  = cmd_err;
  assign Databus      = rd_valid ? rd_data : 'z;
endmodule

// File: tb/tb_bus_ram.sv
// Directed bench: two RAMs (read latency 1 and 2) share one stimulus stream.
// Bus release is checked by driving a probe pattern and reading it back intact.
module tb_bus_ram;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] address = '0;
  logic       write_en = 1'b0, read_en = 1'b0;
  logic       oe1 = 1'b0, oe2 = 1'b0;
  logic [7:0] dout = '0;
  wire  [7:0] db1, db2;
  int         total = 0, bad = 0;

  assign db1 = oe1 ? dout : 'z;
  assign db2 = oe2 ? dout : 'z;

  bus_ram_if #(.ADDR_W(8)) bif1 ();
  bus_ram_if #(.ADDR_W(8)) bif2 ();
  assign bif1.Address = address;
  assign bif1.Write_en = write_en;
  assign bif1.Read_en = read_en;
  assign bif2.Address = address;
  assign bif2.Write_en = write_en;
  assign bif2.Read_en = read_en;

  bus_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1), .Databus(db1));
  bus_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bif2), .Databus(db2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a pattern onto one bus; it reads back intact only if the RAM is off the bus.
  task automatic probe(input string tag, input int which);
    dout = 8'hC3;
    if (which == 1) oe1 = 1'b1; else oe2 = 1'b1;
    #1;
    chk(tag, (which == 1) ? db1 : db2, 8'hC3);
    oe1 = 1'b0;
    oe2 = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; dout = d; write_en = 1'b1; read_en = 1'b0; oe1 = 1'b1; oe2 = 1'b1;
    step();
    write_en = 1'b0; oe1 = 1'b0; oe2 = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_ready1", bif1.Ready, 1'b0);
    chk("rst_rdv1", bif1.Rd_valid, 1'b0);
    chk("rst_aerr1", bif1.Addr_err, 1'b0);
    chk("rst_cerr1", bif1.Cmd_err, 1'b0);
    probe("rst_bus1_z", 1);

    // Clear takes exactly DEPTH cycles after rst falls
    rst = 1'b0;
    step(15);
    chk("clr_ready_edge14", bif1.Ready, 1'b0);
    step();
    chk("clr_ready_edge15", bif1.Ready, 1'b1);
    chk("clr_ready2_edge15", bif2.Ready, 1'b1);

    // Every word zero after clear, back-to-back reads
    for (int i = 0; i < 16; i++) begin
      address = 8'(i); read_en = 1'b1;
      step();
      chk("clr_rdv", bif1.Rd_valid, 1'b1);
      chk("clr_data", db1, 8'h00);
    end
    read_en = 1'b0;
    step(2);

    // Write then read next edge, both latencies
    wr(8'd3, 8'hA5);
    address = 8'd3; read_en = 1'b1;
    probe("pre_bus1_z", 1);
    probe("pre_bus2_z", 2);
    step();
    read_en = 1'b0;
    chk("l1_rdv", bif1.Rd_valid, 1'b1);
    chk("l1_data", db1, 8'hA5);
    chk("l2_rdv_early", bif2.Rd_valid, 1'b0);
    probe("l2_bus_z_early", 2);
    step();
    chk("l1_rdv_end", bif1.Rd_valid, 1'b0);
    probe("l1_bus_z_after", 1);
    chk("l2_rdv", bif2.Rd_valid, 1'b1);
    chk("l2_data", db2, 8'hA5);
    step();
    chk("l2_rdv_end", bif2.Rd_valid, 1'b0);

    // Streaming reads return data in order with continuous Rd_valid
    for (int i = 0; i < 4; i++) wr(8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) begin
      address = 8'(i); read_en = 1'b1;
      step();
      chk("stream_rdv1", bif1.Rd_valid, 1'b1);
      chk("stream_data1", db1, 8'(8'h10 + i));
      if (i > 0) chk("stream_data2", db2, 8'(8'h10 + i - 1));
    end
    read_en = 1'b0;
    step();
    chk("stream_rdv1_end", bif1.Rd_valid, 1'b0);
    chk("stream_rdv2_last", bif2.Rd_valid, 1'b1);
    chk("stream_data2_last", db2, 8'h13);
    step();
    chk("stream_rdv2_end", bif2.Rd_valid, 1'b0);

    // Out-of-range read and write
    address = 8'd20; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("oor_rd_rdv1", bif1.Rd_valid, 1'b1);
    chk("oor_rd_data1", db1, 8'h00);
    chk("oor_rd_aerr1", bif1.Addr_err, 1'b1);
    chk("oor_rd_aerr2_early", bif2.Addr_err, 1'b0);
    step();
    chk("oor_rd_aerr1_end", bif1.Addr_err, 1'b0);
    chk("oor_rd_rdv2", bif2.Rd_valid, 1'b1);
    chk("oor_rd_aerr2", bif2.Addr_err, 1'b1);
    chk("oor_rd_data2", db2, 8'h00);
    step();
    chk("oor_rd_aerr2_end", bif2.Addr_err, 1'b0);
    wr(8'd20, 8'h77);
    chk("oor_wr_aerr1", bif1.Addr_err, 1'b1);
    chk("oor_wr_aerr2", bif2.Addr_err, 1'b1);
    chk("oor_wr_cerr1", bif1.Cmd_err, 1'b0);
    step();
    chk("oor_wr_aerr1_end", bif1.Addr_err, 1'b0);
    address = 8'd4; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("no_alias_data", db1, 8'h00);
    chk("no_alias_aerr", bif1.Addr_err, 1'b0);
    step(2);

    // Write and read together: both dropped, Cmd_err one cycle
    address = 8'd1; dout = 8'h55; write_en = 1'b1; read_en = 1'b1; oe1 = 1'b1; oe2 = 1'b1;
    step();
    write_en = 1'b0; read_en = 1'b0; oe1 = 1'b0; oe2 = 1'b0;
    chk("both_cerr1", bif1.Cmd_err, 1'b1);
    chk("both_cerr2", bif2.Cmd_err, 1'b1);
    chk("both_rdv1", bif1.Rd_valid, 1'b0);
    step();
    chk("both_cerr1_end", bif1.Cmd_err, 1'b0);
    address = 8'd1; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("both_mem_kept", db1, 8'h11);
    step(2);

    // Write while a read is in flight is rejected
    address = 8'd2; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("inflt_rd_data", db1, 8'h12);
    address = 8'd2; dout = 8'h66; write_en = 1'b1; oe1 = 1'b1; oe2 = 1'b1;
    step();
    write_en = 1'b0; oe1 = 1'b0; oe2 = 1'b0;
    chk("inflt_cerr1", bif1.Cmd_err, 1'b1);
    chk("inflt_cerr2", bif2.Cmd_err, 1'b1);
    step();
    chk("inflt_cerr1_end", bif1.Cmd_err, 1'b0);
    step();
    address = 8'd2; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("inflt_mem_kept", db1, 8'h12);
    step(2);

    // Reset in the middle of clear restarts the fill
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(7);
    chk("midclr_ready", bif1.Ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(15);
    chk("reclr_ready_edge14", bif1.Ready, 1'b0);
    step();
    chk("reclr_ready_edge15", bif1.Ready, 1'b1);
    address = 8'd2; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("reclr_zeroed", db1, 8'h00);
    step(2);

    // Reset during Rd_valid releases the bus immediately
    wr(8'd5, 8'h5A);
    address = 8'd5; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rstrd_data", db1, 8'h5A);
    rst = 1'b1;
    #1;
    chk("rstrd_rdv1", bif1.Rd_valid, 1'b0);
    chk("rstrd_ready", bif1.Ready, 1'b0);
    probe("rstrd_bus1_z", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port data RAM for the processor's shared memory bus. It has a bidirectional data bus, a configurable read latency (1 or 2 cycles) and a sequencer that zero-fills the array after reset. It reports address-range and protocol errors. It sits between the CPU datapath and the memory-mapped bus, replacing the fixed 16×8 array.

## Interface
- DATA_W, 8: data word width
- ADDR_W, 8: address bus width
- DEPTH, 16: number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- READ_LAT, 1: read latency in cycles; legal values 1 or 2
- CLEAR_ON_RESET, 1: 1 = zero-fill the array after reset; 0 = contents undefined, no fill

Ports:
- clk  in  1  single clock; everything samples on its rising edge
- rst  in  1  asynchronous, active-high reset
- Address  in  ADDR_W  word address, sampled with Write_en/Read_en
- Databus  inout  DATA_W  shared data bus; driven by the RAM only while Rd_valid=1, else Z
- Write_en  in  1  write request, sampled at the rising edge
- Read_en  in  1  read request, sampled at the rising edge
- Ready  out  1  1 = requests are accepted (state IDLE)
- Rd_valid  out  1  1 = read data is on Databus this cycle
- Addr_err  out  1  1-cycle pulse: an accepted request had Address ≥ DEPTH
- Cmd_err  out  1  1-cycle pulse: a request was rejected by protocol rules

## Operation
- States: CLEAR and IDLE.
- rst asserted → state CLEAR if CLEAR_ON_RESET=1, else IDLE.
- CLEAR:
  - Clear counter starts at 0, writes 0 to Cel[counter] and increments once per cycle.
  - After writing DEPTH-1 → IDLE.
  - Requests seen in CLEAR are ignored; no error is flagged.
- IDLE, write: Write_en=1 and Read_en=0 and the read pipeline is empty → Cel[Address] ← Databus at that edge.
- IDLE, read: Read_en=1 and Write_en=0 → request enters the read pipeline.
  - Data is Cel[Address] as of that edge, so a write in the preceding cycle is visible.
  - One read may be accepted every cycle.
- Address ≥ DEPTH:
  - Write: dropped, Addr_err pulses.
  - Read: still occupies a pipeline slot, returns all-zero data, Addr_err pulses coincident with its Rd_valid.
- Write_en=1 and Read_en=1 in the same cycle → neither is performed, Cmd_err pulses.
- Write_en while any read is in flight → rejected, Cmd_err pulses. This avoids contention on Databus.
- No aliasing: the address is never truncated modulo DEPTH.

## Timing
- Reset values (asynchronous, effective immediately):
  - Ready = 0 if CLEAR_ON_RESET=1, else 1.
  - Rd_valid = 0, Addr_err = 0, Cmd_err = 0, Databus = Z.
  - Read pipeline flushed; clear counter = 0.
- Clear duration: with rst falling before edge 0, Ready rises after edge DEPTH-1, i.e. exactly DEPTH cycles.
- Read latency:
  - Read sampled at edge t → Rd_valid=1 and Databus valid between edge t+READ_LAT-1 and edge t+READ_LAT.
  - Back-to-back reads give continuous Rd_valid.
- Write takes effect at the sampling edge; a read sampled at the next edge returns the new value.
- Addr_err and Cmd_err are registered, high for exactly one cycle after the offending edge. The exception is the Addr_err of a read, which is aligned with that read's Rd_valid.
- Reset mid-clear restarts the clear from 0. Reset mid-read drops Rd_valid and tristates Databus asynchronously.
- Databus output enable is Rd_valid, registered; there is no combinational path from Read_en to Databus.

## Structure
- Shared package bus_ram_pkg holds:
  - State encodings ST_CLEAR, ST_IDLE.
  - The clog2 constant function used to size the clear counter (clog2(DEPTH)).
  - Legal READ_LAT values.
- Sub-module bus_ram_rd_pipe: READ_LAT-deep valid/data/err shift register producing Rd_valid, read data and the aligned Addr_err.
- The top level owns the array, the FSM, the clear counter and the error logic.

## Test plan
- Reset, then wait (defaults): Ready goes high exactly 16 cycles after rst falls; reads of addresses 0..15 all return 0x00.
- Write 0xA5 to 3, then read 3 on the next edge (READ_LAT=1 and 2): Databus = 0xA5 with Rd_valid one (or two) cycles after the sample; Databus = Z otherwise.
- Continuous reads of addresses 0..3 after writing 0x10..0x13: Rd_valid is high for 4 consecutive cycles with data 0x10, 0x11, 0x12, 0x13 in order.
- Read of address 20 with DEPTH=16: returns 0x00 with Rd_valid=1 and Addr_err=1 in the same cycle. Write 0x77 to address 20: Addr_err pulses, and address 4 (20 mod 16) remains unchanged.
- Write_en and Read_en high together, and Write_en during an in-flight read: Cmd_err pulses for 1 cycle and the memory is unchanged.
- rst asserted at clear count 7, then released: Ready rises 16 cycles after release. rst asserted while Rd_valid=1: Databus goes to Z immediately.
